load_store_unit: RTL and testbench
==================================

# load_store_unit

Multi-cycle data-memory access unit between the single-cycle core datapath and the data RAM bus. It takes the datapath's ALU address and rs2 value, performs byte/halfword/word loads and stores with byte enables, and returns aligned, sign- or zero-extended load data. It stalls the core while the bus transaction is outstanding. It also reports misaligned accesses and bus timeouts to the trap logic.

## Interface
- TIMEOUT_CYCLES, 255, maximum cycles in BUSY without `bus_ack` before an access fault; must be ≥1.
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- mem_read  in  1  current instruction is a load.
- mem_write  in  1  current instruction is a store; wins if both are high.
- funct3  in  3  access size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu; 011/110/111 treated as w.
- addr_in  in  32  byte address (datapath ALU result).
- wdata_in  in  32  store data (rs2).
- rdata_out  out  32  extended load result to the datapath write-back mux.
- stall  out  1  hold PC and suppress register/CSR write this cycle.
- misalign  out  1  one-cycle pulse: misaligned access rejected.
- access_fault  out  1  one-cycle pulse: bus timeout.
- bus_req  out  1  request valid, held until ack.
- bus_we  out  1  request is a write.
- bus_addr  out  32  word address, `{addr_in[31:2],2'b00}`.
- bus_be  out  4  byte enables.
- bus_wdata  out  32  lane-replicated store data.
- bus_ack  in  1  request accepted/completed; `bus_rdata` is valid in the same cycle.
- bus_rdata  in  32  read word.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE, no access: `stall`=0, outputs hold at 0.
- IDLE, access, aligned: `stall`=1 combinationally. At the edge, latch the following and go to BUSY:
  - `bus_addr`, `bus_we`, `bus_be`, `bus_wdata`;
  - `funct3` and `addr_in[1:0]`;
  - `bus_req`=1.
- IDLE, access, misaligned: `misalign`=1 combinationally, `stall`=0, no bus request, state stays IDLE. Misaligned means:
  - h/hu with `addr[0]`=1;
  - w with `addr[1:0]`≠0.
- BUSY: `stall`=1 and the timeout counter increments.
  - `bus_ack`=1: capture `bus_rdata`, drop `bus_req`, go to DONE.
  - Counter reaches TIMEOUT_CYCLES: drop `bus_req`, set the fault flag, go to DONE.
- DONE: `stall`=0 and `rdata_out` is valid, so the core retires the instruction at this edge. `access_fault`=1 if the fault flag is set. No new access starts in DONE even though `mem_read`/`mem_write` are still high. Next state is IDLE.
- Byte enables: b → `4'b0001<<addr[1:0]`; h → `4'b0011<<addr[1:0]`; w → `4'b1111`.
- Store data: b → `{4{wdata[7:0]}}`; h → `{2{wdata[15:0]}}`; w → `wdata`.
- Load extract: take the byte/half selected by the latched `addr[1:0]`. Sign-extend for b/h, zero-extend for bu/hu.
- `rdata_out` is 0 for stores, faulted accesses, and every state except DONE.
- `bus_ack` outside BUSY is ignored.

## Timing
- Reset (async, any state): state→IDLE, counter→0. All outputs are 0: `bus_req`, `bus_we`, `bus_addr`, `bus_be`, `bus_wdata`, `rdata_out`, `stall`, `misalign`, `access_fault`. An in-flight request is abandoned with no completion.
- Best-case latency: access seen in cycle 0 (IDLE), `bus_req` in cycle 1 with ack in cycle 1, DONE in cycle 2. The instruction occupies 3 cycles; `stall` is high in cycles 0–1.
- Each extra wait cycle of ack adds one stall cycle.
- `bus_req` and the address/data/enable outputs are registered and stable from assertion until the ack cycle inclusive.
- Timeout: with ack never arriving, DONE is reached TIMEOUT_CYCLES cycles after BUSY entry, and `access_fault` pulses in DONE.
- `misalign` is combinational in the IDLE cycle. The trap logic samples it at that edge.

## Structure
- Package `lsu_pkg` holds:
  - the state enum (IDLE/BUSY/DONE);
  - funct3 size constants (LSU_B, LSU_H, LSU_W, LSU_BU, LSU_HU);
  - the counter width derived from TIMEOUT_CYCLES.
- Sub-module `load_extend`: combinational, inputs are word, offset and funct3, output is the extended result. It is used in DONE.
- Store lane/enable generation stays inline in the top module.

## Test plan
- lw at 0x100, ack in first BUSY cycle with `bus_rdata`=0xDEADBEEF → `bus_addr`=0x100, `bus_be`=1111, `stall` high 2 cycles, `rdata_out`=0xDEADBEEF in DONE.
- lb at 0x203, `bus_rdata`=0x80AABBCC → `bus_be`=1000, `rdata_out`=0xFFFFFF80. lbu at the same address → 0x00000080. lhu at 0x202 → 0x000080AA.
- sb at 0x101 with `wdata`=0x12345678 → `bus_we`=1, `bus_be`=0010, `bus_wdata`=0x78787878. sh at 0x102 → `bus_be`=1100, `bus_wdata`=0x56785678.
- lw at 0x102 → `misalign`=1 for one cycle, `bus_req` never asserted, `stall`=0.
- TIMEOUT_CYCLES=4, load with ack held low → `bus_req` high 4 cycles then drops, DONE with `access_fault`=1 and `rdata_out`=0. A late ack afterwards is ignored.
- Assert `rst` while in BUSY with `bus_req`=1 → all outputs 0 immediately. After release, a fresh lw completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types, access-size encodings and helpers for the load/store unit
package lsu_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} lsu_state_e;

    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} lsu_size_e;

    localparam logic [2:0] LSU_B  = 3'b000;
    localparam logic [2:0] LSU_H  = 3'b001;
    localparam logic [2:0] LSU_W  = 3'b010;
    localparam logic [2:0] LSU_BU = 3'b100;
    localparam logic [2:0] LSU_HU = 3'b101;

    // Unlisted encodings (011/110/111) fall through to word accesses
    function automatic lsu_size_e lsu_size(input logic [2:0] f3);
        case (f3)
            LSU_B, LSU_BU: return SZ_B;
            LSU_H, LSU_HU: return SZ_H;
            LSU_W:         return SZ_W;
            default:       return SZ_W;
        endcase
    endfunction

    // The counter only has to reach TIMEOUT_CYCLES-1
    function automatic int lsu_cnt_width(input int n);
        return n < 2 ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/load_extend.sv
// load_extend: selects the addressed byte/half of a read word and sign- or zero-extends it
module load_extend
    import lsu_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  offset_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] result_o
);
    lsu_size_e   size;
    logic        sx;
    logic [7:0]  b;
    logic [15:0] h;

    assign size = lsu_size(funct3_i);
    assign sx   = !(funct3_i == LSU_BU || funct3_i == LSU_HU);
    assign b    = word_i[{offset_i, 3'b000} +: 8];
    assign h    = word_i[{offset_i[1], 4'b0000} +: 16];

    // Word accesses pass through untouched
    always_comb begin
        result_o = size == SZ_B ? {{24{sx & b[7]}}, b} :
                   size == SZ_H ? {{16{sx & h[15]}}, h} : word_i;
    end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: multi-cycle data-memory access unit with stall, misalign and bus-timeout reporting
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr_in,
    input  logic [31:0] wdata_in,
    output logic [31:0] rdata_out,
    output logic        stall,
    output logic        misalign,
    output logic        access_fault,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);
    localparam int            CW       = lsu_cnt_width(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    lsu_state_e    state_q;
    logic [CW-1:0] cnt_q;
    logic          req_q, we_q, fault_q;
    logic [31:0]   addr_q, wdata_q, rword_q, ext;
    logic [3:0]    be_q;
    logic [2:0]    f3_q;
    logic [1:0]    off_q;
    lsu_size_e     size;
    logic          idle_acc, misaligned;
    logic [3:0]    be_d;
    logic [31:0]   wdata_d;

    assign size       = lsu_size(funct3);
    assign misaligned = (size == SZ_H && addr_in[0]) || (size == SZ_W && addr_in[1:0] != 2'b00);
    assign idle_acc   = !rst && state_q == IDLE && (mem_read | mem_write);

    assign stall        = (idle_acc && !misaligned) || (!rst && state_q == BUSY);
    assign misalign     = idle_acc && misaligned;
    assign access_fault = state_q == DONE && fault_q;
    assign rdata_out    = state_q == DONE ? ext : '0;
    assign bus_req      = req_q;
    assign bus_we       = we_q;
    assign bus_addr     = addr_q;
    assign bus_be       = be_q;
    assign bus_wdata    = wdata_q;

    // Byte enables and lane-replicated store data for the access about to be issued
    always_comb begin
        be_d    = size == SZ_B ? 4'b0001 << addr_in[1:0] :
                  size == SZ_H ? 4'b0011 << addr_in[1:0] : 4'b1111;
        wdata_d = size == SZ_B ? {4{wdata_in[7:0]}} :
                  size == SZ_H ? {2{wdata_in[15:0]}} : wdata_in;
    end

    // Access sequencing; bus outputs are registered and cleared whenever BUSY ends
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            f3_q    <= '0;
            off_q   <= '0;
            rword_q <= '0;
            fault_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (idle_acc && !misaligned) begin
                    state_q <= BUSY;
                    cnt_q   <= '0;
                    req_q   <= 1'b1;
                    we_q    <= mem_write;
                    addr_q  <= {addr_in[31:2], 2'b00};
                    be_q    <= be_d;
                    wdata_q <= wdata_d;
                    f3_q    <= funct3;
                    off_q   <= addr_in[1:0];
                    rword_q <= '0;
                    fault_q <= 1'b0;
                end
                BUSY: if (bus_ack || cnt_q == CNT_LAST) begin
                    state_q <= DONE;
                    req_q   <= 1'b0;
                    we_q    <= 1'b0;
                    addr_q  <= '0;
                    be_q    <= '0;
                    wdata_q <= '0;
                    rword_q <= bus_ack && !we_q ? bus_rdata : '0;
                    fault_q <= !bus_ack;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    load_extend u_ext (
        .word_i   (rword_q),
        .offset_i (off_q),
        .funct3_i (f3_q),
        .result_o (ext)
    );
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: cycle-by-cycle check of the load/store unit against a transaction-level model
module tb_load_store_unit;
    localparam int T = 4;

    logic        clk = 1'b0, rst = 1'b1;
    logic        mem_read = 1'b0, mem_write = 1'b0, bus_ack = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] addr_in = '0, wdata_in = '0, bus_rdata = '0;
    logic [31:0] rdata_out, bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        stall, misalign, access_fault, bus_req, bus_we;

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3),
        .addr_in(addr_in), .wdata_in(wdata_in), .rdata_out(rdata_out), .stall(stall),
        .misalign(misalign), .access_fault(access_fault), .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_ack(bus_ack),
        .bus_rdata(bus_rdata)
    );

    int vectors = 0, errors = 0;
    int tot_stall = 0, tot_req = 0, tot_mis = 0;
    logic        chk_en = 1'b0, exp_done = 1'b0;
    logic        exp_req, exp_we, exp_stall, exp_mis, exp_fault;
    logic [31:0] exp_rdata, exp_addr, exp_wdata;
    logic [3:0]  exp_be;
    logic [31:0] last_rdata = '0, last_addr = '0, last_wdata = '0;
    logic [3:0]  last_be = '0;
    logic        last_we = 1'b0, last_fault = 1'b0;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        vectors++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
        end
    endtask

    function automatic int sz_of(input logic [2:0] f3);
        return f3[1:0] == 2'd0 ? 1 : f3[1:0] == 2'd1 ? 2 : 4;
    endfunction

    function automatic logic [31:0] ext_of(input logic [31:0] w, input logic [31:0] a, input logic [2:0] f3);
        int n = sz_of(f3);
        logic [31:0] m, v;
        if (n == 4) return w;
        m = (32'd1 << (8 * n)) - 1;
        v = (w >> (8 * (a % 4))) & m;
        if (!f3[2] && v[8 * n - 1]) v = v | ~m;
        return v;
    endfunction

    task automatic zero_exp();
        exp_req = 0; exp_we = 0; exp_addr = 0; exp_be = 0; exp_wdata = 0;
        exp_stall = 0; exp_mis = 0; exp_rdata = 0; exp_fault = 0; exp_done = 0;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle(input logic ack);
        mem_read = 0; mem_write = 0; funct3 = 3'($urandom); addr_in = $urandom;
        wdata_in = $urandom; bus_ack = ack; bus_rdata = $urandom;
        zero_exp();
        nxt();
    endtask

    // d = index of the BUSY cycle carrying the ack; d >= T means ack never comes
    task automatic run_instr(input logic rd, input logic wr, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] wd, input int d,
                             input logic [31:0] word);
        int n = sz_of(f3);
        int k;
        logic acc = rd | wr;
        logic mis = acc && (a % n != 0);
        mem_read = rd; mem_write = wr; funct3 = f3; addr_in = a; wdata_in = wd;
        bus_ack = 1'($urandom); bus_rdata = $urandom;
        zero_exp();
        exp_stall = acc && !mis;
        exp_mis = mis;
        nxt();
        if (!acc || mis) return;
        k = d < T ? d + 1 : T;
        for (int i = 0; i < k; i++) begin
            bus_ack = (i == d);
            bus_rdata = (i == d) ? word : $urandom;
            exp_req = 1; exp_we = wr; exp_addr = a & ~32'd3;
            exp_be = 4'(((1 << n) - 1) << (a % 4));
            exp_wdata = n == 1 ? {24'd0, wd[7:0]} * 32'h01010101 :
                        n == 2 ? {16'd0, wd[15:0]} * 32'h00010001 : wd;
            exp_stall = 1; exp_mis = 0;
            nxt();
        end
        bus_ack = 1'($urandom); bus_rdata = $urandom;
        zero_exp();
        exp_done = 1;
        exp_fault = d >= T;
        exp_rdata = (d < T && !wr) ? ext_of(word, a, f3) : 32'd0;
        nxt();
        exp_done = 0;
    endtask

    task automatic outputs_zero(input string tag);
        chk({tag, "_req"}, bus_req, 0);
        chk({tag, "_we"}, bus_we, 0);
        chk({tag, "_addr"}, bus_addr, 0);
        chk({tag, "_be"}, bus_be, 0);
        chk({tag, "_wdata"}, bus_wdata, 0);
        chk({tag, "_rdata"}, rdata_out, 0);
        chk({tag, "_stall"}, stall, 0);
        chk({tag, "_mis"}, misalign, 0);
        chk({tag, "_fault"}, access_fault, 0);
    endtask

    initial begin
        int s_stall, s_req, s_mis, d;
        logic rd, wr;
        zero_exp();
        chk_en = 1;
        fork
            forever begin
                @(negedge clk);
                if (chk_en) begin
                    chk("bus_req", bus_req, exp_req);
                    chk("bus_we", bus_we, exp_we);
                    chk("bus_addr", bus_addr, exp_addr);
                    chk("bus_be", bus_be, exp_be);
                    chk("bus_wdata", bus_wdata, exp_wdata);
                    chk("stall", stall, exp_stall);
                    chk("misalign", misalign, exp_mis);
                    chk("rdata_out", rdata_out, exp_rdata);
                    chk("access_fault", access_fault, exp_fault);
                    tot_stall += int'(stall);
                    tot_req += int'(bus_req);
                    tot_mis += int'(misalign);
                    if (bus_req) begin
                        last_addr = bus_addr; last_be = bus_be; last_wdata = bus_wdata; last_we = bus_we;
                    end
                    if (exp_done) begin
                        last_rdata = rdata_out; last_fault = access_fault;
                    end
                end
            end
        join_none

        nxt();
        outputs_zero("reset");
        nxt();
        rst = 0;
        idle_cycle(1);

        s_stall = tot_stall;
        run_instr(1, 0, 3'b010, 32'h100, 32'h0, 0, 32'hDEADBEEF);
        chk("lw_addr", last_addr, 32'h100);
        chk("lw_be", last_be, 4'b1111);
        chk("lw_stall_cycles", tot_stall - s_stall, 2);
        chk("lw_rdata", last_rdata, 32'hDEADBEEF);

        run_instr(1, 0, 3'b000, 32'h203, 32'h0, 1, 32'h80AABBCC);
        chk("lb_be", last_be, 4'b1000);
        chk("lb_rdata", last_rdata, 32'hFFFFFF80);
        run_instr(1, 0, 3'b100, 32'h203, 32'h0, 0, 32'h80AABBCC);
        chk("lbu_rdata", last_rdata, 32'h00000080);
        run_instr(1, 0, 3'b101, 32'h202, 32'h0, 2, 32'h80AABBCC);
        chk("lhu_rdata", last_rdata, 32'h000080AA);

        run_instr(0, 1, 3'b000, 32'h101, 32'h12345678, 0, 32'h0);
        chk("sb_we", last_we, 1);
        chk("sb_be", last_be, 4'b0010);
        chk("sb_wdata", last_wdata, 32'h78787878);
        chk("sb_rdata", last_rdata, 0);
        run_instr(0, 1, 3'b001, 32'h102, 32'h12345678, 1, 32'h0);
        chk("sh_be", last_be, 4'b1100);
        chk("sh_wdata", last_wdata, 32'h56785678);

        s_stall = tot_stall; s_req = tot_req; s_mis = tot_mis;
        run_instr(1, 0, 3'b010, 32'h102, 32'h0, 0, 32'h0);
        idle_cycle(0);
        chk("mis_pulses", tot_mis - s_mis, 1);
        chk("mis_req_cycles", tot_req - s_req, 0);
        chk("mis_stall_cycles", tot_stall - s_stall, 0);

        s_req = tot_req;
        run_instr(1, 0, 3'b010, 32'h40, 32'h0, 1000, 32'h0);
        chk("to_req_cycles", tot_req - s_req, T);
        chk("to_fault", last_fault, 1);
        chk("to_rdata", last_rdata, 0);
        idle_cycle(1);
        idle_cycle(1);

        mem_read = 1; mem_write = 0; funct3 = 3'b010; addr_in = 32'h300; bus_ack = 0;
        zero_exp(); exp_stall = 1;
        nxt();
        zero_exp(); exp_req = 1; exp_addr = 32'h300; exp_be = 4'hF; exp_stall = 1;
        chk("rst_pre_req", bus_req, 1);
        rst = 1;
        zero_exp();
        #1;
        outputs_zero("rst_async");
        nxt();
        nxt();
        rst = 0;
        idle_cycle(1);
        run_instr(1, 0, 3'b010, 32'h300, 32'h0, 0, 32'hCAFEF00D);
        chk("post_rst_rdata", last_rdata, 32'hCAFEF00D);

        for (int i = 0; i < 300; i++) begin
            rd = 1'($urandom); wr = 1'($urandom);
            d = $urandom_range(0, 9) > 8 ? T + 2 : $urandom_range(0, T - 1);
            run_instr(rd, wr, 3'($urandom), {$urandom_range(0, 1) == 0 ? 30'($urandom) : 30'd0, 2'($urandom)},
                      $urandom, d, $urandom);
            if ($urandom_range(0, 3) == 0) idle_cycle(1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
